// File: rtl/quad_cmd_pkg.sv
// Shared definitions for the quadcopter command link: opcodes, the positive
// acknowledge byte and the cmd_snd state encoding.
package quad_cmd_pkg;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] POS_ACK   = 8'hA5;

    // Retries after the first attempt when CMD_SND_RETRY_EN is defined
    localparam logic [1:0] MAX_RETRY = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_HI,
        TX_LO,
        WAIT_RESP
    } cmd_snd_state_t;

endpackage

// File: rtl/cmd_snd_if.sv
// UART-side link of cmd_snd: TX byte handshake plus RX byte hand-off.
interface cmd_snd_if;

    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;

    modport master (
        output tx_data, trmt, clr_rx_rdy,
        input  tx_done, rx_rdy, rx_data
    );

    modport slave (
        input  tx_data, trmt, clr_rx_rdy,
        output tx_done, rx_rdy, rx_data
    );

endinterface

// File: rtl/cmd_snd_tmr.sv
// Clearable saturating response-timeout counter; sat is high at all ones.
module cmd_snd_tmr #(
    parameter int unsigned TMO_WIDTH = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sat
);

    logic [TMO_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !sat)
            cnt <= cnt + TMO_WIDTH'(1);
    end

    assign sat = &cnt;

endmodule

// File: rtl/cmd_snd.sv
// Remote-side command sender: opcode/data-high/data-low out over UART, then one
// response byte back with timeout. Optional macro: CMD_SND_RETRY_EN.
module cmd_snd
    import quad_cmd_pkg::*;
#(
    parameter int unsigned TMO_WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snd_cmd,
    input  logic [7:0]       cmd,
    input  logic [15:0]      data,
    cmd_snd_if.master        uart,
    output logic             cmd_busy,
    output logic [7:0]       resp,
    output logic             resp_rdy,
    output logic             resp_ack,
    output logic             timeout_err
);

    cmd_snd_state_t state_q, state_nxt;
    logic [7:0]  tx_data_q, tx_data_nxt;
    logic        trmt_q, trmt_nxt;
    logic        clr_q, clr_nxt;
    logic        busy_nxt, rdy_nxt, ack_nxt, err_nxt;
    logic [7:0]  resp_nxt;
    logic [15:0] data_l_q, data_l_nxt;
    logic        rx_new;
    logic        tmr_clr, tmr_en, tmr_sat;
`ifdef CMD_SND_RETRY_EN
    logic [7:0]  cmd_l_q, cmd_l_nxt;
    logic [1:0]  retry_q, retry_nxt;
`endif

    cmd_snd_tmr #(.TMO_WIDTH(TMO_WIDTH)) u_tmr (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .sat (tmr_sat)
    );

    assign tmr_en          = (state_q == WAIT_RESP);
    assign uart.tx_data    = tx_data_q;
    assign uart.trmt       = trmt_q;
    assign uart.clr_rx_rdy = clr_q;

    always_comb begin
        state_nxt   = state_q;
        tx_data_nxt = tx_data_q;
        trmt_nxt    = 1'b0;
        clr_nxt     = 1'b0;
        busy_nxt    = cmd_busy;
        resp_nxt    = resp;
        rdy_nxt     = 1'b0;
        ack_nxt     = resp_ack;
        err_nxt     = timeout_err;
        data_l_nxt  = data_l_q;
        tmr_clr     = 1'b0;
`ifdef CMD_SND_RETRY_EN
        cmd_l_nxt   = cmd_l_q;
        retry_nxt   = retry_q;
`endif
        // rx_rdy is still high the cycle our clear pulse is out; not a new byte
        rx_new = uart.rx_rdy && !clr_q;
        if (rx_new && state_q != WAIT_RESP)
            clr_nxt = 1'b1;

        case (state_q)
            IDLE: if (snd_cmd) begin
                data_l_nxt  = data;
                busy_nxt    = 1'b1;
                err_nxt     = 1'b0;
                ack_nxt     = 1'b0;
                tx_data_nxt = cmd;
                trmt_nxt    = 1'b1;
`ifdef CMD_SND_RETRY_EN
                cmd_l_nxt   = cmd;
                retry_nxt   = '0;
`endif
                state_nxt   = TX_CMD;
            end
            TX_CMD: if (uart.tx_done) begin
                tx_data_nxt = data_l_q[15:8];
                trmt_nxt    = 1'b1;
                state_nxt   = TX_HI;
            end
            TX_HI: if (uart.tx_done) begin
                tx_data_nxt = data_l_q[7:0];
                trmt_nxt    = 1'b1;
                state_nxt   = TX_LO;
            end
            TX_LO: if (uart.tx_done) begin
                tmr_clr   = 1'b1;
                state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (rx_new) begin
                    resp_nxt  = uart.rx_data;
                    rdy_nxt   = 1'b1;
                    clr_nxt   = 1'b1;
                    ack_nxt   = (uart.rx_data == POS_ACK);
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (tmr_sat) begin
`ifdef CMD_SND_RETRY_EN
                    if (retry_q != MAX_RETRY) begin
                        retry_nxt   = retry_q + 2'd1;
                        tx_data_nxt = cmd_l_q;
                        trmt_nxt    = 1'b1;
                        state_nxt   = TX_CMD;
                    end else begin
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
`else
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            clr_q       <= 1'b0;
            cmd_busy    <= 1'b0;
            resp        <= '0;
            resp_rdy    <= 1'b0;
            resp_ack    <= 1'b0;
            timeout_err <= 1'b0;
            data_l_q    <= '0;
`ifdef CMD_SND_RETRY_EN
            cmd_l_q     <= '0;
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_nxt;
            tx_data_q   <= tx_data_nxt;
            trmt_q      <= trmt_nxt;
            clr_q       <= clr_nxt;
            cmd_busy    <= busy_nxt;
            resp        <= resp_nxt;
            resp_rdy    <= rdy_nxt;
            resp_ack    <= ack_nxt;
            timeout_err <= err_nxt;
            data_l_q    <= data_l_nxt;
`ifdef CMD_SND_RETRY_EN
            cmd_l_q     <= cmd_l_nxt;
            retry_q     <= retry_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_cmd_snd.sv
// Directed self-checking bench for cmd_snd (TMO_WIDTH=4); honours CMD_SND_RETRY_EN.
module tb_cmd_snd;

    logic        clk = 1'b0;
    logic        rst;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_busy;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        resp_ack;
    logic        timeout_err;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    cmd_snd_if uart_if ();

    cmd_snd #(.TMO_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .snd_cmd     (snd_cmd),
        .cmd         (cmd),
        .data        (data),
        .uart        (uart_if.master),
        .cmd_busy    (cmd_busy),
        .resp        (resp),
        .resp_rdy    (resp_rdy),
        .resp_ack    (resp_ack),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] c, input logic [15:0] d);
        snd_cmd = 1'b1; cmd = c; data = d;
        tick();
        snd_cmd = 1'b0;
        chk("start_trmt", 16'(uart_if.trmt), 16'h1);
        chk("start_byte", 16'(uart_if.tx_data), 16'(c));
        chk("start_busy", 16'(cmd_busy), 16'h1);
        chk("start_err", 16'(timeout_err), 16'h0);
        chk("start_ack", 16'(resp_ack), 16'h0);
        tick();
        chk("gap_trmt", 16'(uart_if.trmt), 16'h0);
    endtask

    task automatic byte_step(input string tag, input logic [7:0] b);
        uart_if.tx_done = 1'b1;
        tick();
        uart_if.tx_done = 1'b0;
        chk({tag, "_trmt"}, 16'(uart_if.trmt), 16'h1);
        chk({tag, "_byte"}, 16'(uart_if.tx_data), 16'(b));
        tick();
        chk({tag, "_gap"}, 16'(uart_if.trmt), 16'h0);
    endtask

    task automatic to_wait();
        uart_if.tx_done = 1'b1;
        tick();
        uart_if.tx_done = 1'b0;
        chk("wait_trmt", 16'(uart_if.trmt), 16'h0);
        chk("wait_busy", 16'(cmd_busy), 16'h1);
    endtask

    task automatic respond(input logic [7:0] b, input logic exp_ack);
        uart_if.rx_data = b;
        uart_if.rx_rdy  = 1'b1;
        tick();
        uart_if.rx_rdy  = 1'b0;
        chk("resp_val", 16'(resp), 16'(b));
        chk("resp_rdy", 16'(resp_rdy), 16'h1);
        chk("resp_clr", 16'(uart_if.clr_rx_rdy), 16'h1);
        chk("resp_ack", 16'(resp_ack), 16'(exp_ack));
        chk("resp_busy", 16'(cmd_busy), 16'h0);
        chk("resp_err", 16'(timeout_err), 16'h0);
        tick();
        chk("resp_rdy_pulse", 16'(resp_rdy), 16'h0);
        chk("resp_clr_pulse", 16'(uart_if.clr_rx_rdy), 16'h0);
        chk("resp_ack_hold", 16'(resp_ack), 16'(exp_ack));
    endtask

    initial begin
        rst = 1'b1; snd_cmd = 1'b0; cmd = '0; data = '0;
        uart_if.tx_done = 1'b0; uart_if.rx_rdy = 1'b0; uart_if.rx_data = '0;
        tick();
        chk("rst_tx_data", 16'(uart_if.tx_data), 16'h0);
        chk("rst_trmt", 16'(uart_if.trmt), 16'h0);
        chk("rst_busy", 16'(cmd_busy), 16'h0);
        chk("rst_resp", 16'(resp), 16'h0);
        chk("rst_err", 16'(timeout_err), 16'h0);
        rst = 1'b0;
        tick();

        // Basic frame, positive acknowledge
        start(8'h02, 16'h1234);
        byte_step("hi1", 8'h12);
        byte_step("lo1", 8'h34);
        to_wait();
        respond(8'hA5, 1'b1);

        // Non-ack response
        start(8'h01, 16'h0000);
        byte_step("hi2", 8'h00);
        byte_step("lo2", 8'h00);
        to_wait();
        respond(8'h7C, 1'b0);

        // snd_cmd during TX_HI is ignored
        start(8'h03, 16'hABCD);
        byte_step("hi3", 8'hAB);
        snd_cmd = 1'b1; cmd = 8'h08; data = 16'hFFFF;
        tick();
        snd_cmd = 1'b0;
        chk("ign_trmt", 16'(uart_if.trmt), 16'h0);
        byte_step("lo3", 8'hCD);
        to_wait();
        tick();
        chk("ign_no4th", 16'(uart_if.trmt), 16'h0);
        respond(8'h5A, 1'b0);

        // Stale rx byte in IDLE
        uart_if.rx_data = 8'h55;
        uart_if.rx_rdy  = 1'b1;
        tick();
        uart_if.rx_rdy  = 1'b0;
        chk("stale_clr", 16'(uart_if.clr_rx_rdy), 16'h1);
        chk("stale_resp", 16'(resp), 16'h5A);
        chk("stale_rdy", 16'(resp_rdy), 16'h0);
        tick();
        chk("stale_clr_pulse", 16'(uart_if.clr_rx_rdy), 16'h0);

        // Timeout: 16 cycles in WAIT_RESP per attempt
        start(8'h04, 16'h0102);
        byte_step("hi4", 8'h01);
        byte_step("lo4", 8'h02);
        to_wait();
`ifdef CMD_SND_RETRY_EN
        for (int unsigned a = 0; a < 2; a++) begin
            for (int unsigned i = 0; i < 15; i++) tick();
            chk("retry_pre_err", 16'(timeout_err), 16'h0);
            tick();
            chk("retry_trmt", 16'(uart_if.trmt), 16'h1);
            chk("retry_byte", 16'(uart_if.tx_data), 16'h04);
            chk("retry_busy", 16'(cmd_busy), 16'h1);
            chk("retry_err", 16'(timeout_err), 16'h0);
            tick();
            byte_step("hi4r", 8'h01);
            byte_step("lo4r", 8'h02);
            to_wait();
        end
`endif
        for (int unsigned i = 0; i < 15; i++) tick();
        chk("tmo_pre_err", 16'(timeout_err), 16'h0);
        chk("tmo_pre_busy", 16'(cmd_busy), 16'h1);
        tick();
        chk("tmo_err", 16'(timeout_err), 16'h1);
        chk("tmo_busy", 16'(cmd_busy), 16'h0);
        chk("tmo_trmt", 16'(uart_if.trmt), 16'h0);
        tick();
        chk("tmo_err_sticky", 16'(timeout_err), 16'h1);

        // Response coincident with saturation wins
        start(8'h06, 16'h00FF);
        byte_step("hi5", 8'h00);
        byte_step("lo5", 8'hFF);
        to_wait();
        for (int unsigned i = 0; i < 15; i++) tick();
        respond(8'hA5, 1'b1);

        // Asynchronous reset mid-frame (TX_LO)
        start(8'h07, 16'h9988);
        byte_step("hi6", 8'h99);
        uart_if.tx_done = 1'b1;
        tick();
        uart_if.tx_done = 1'b0;
        chk("pre_rst_trmt", 16'(uart_if.trmt), 16'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx_data", 16'(uart_if.tx_data), 16'h0);
        chk("arst_trmt", 16'(uart_if.trmt), 16'h0);
        chk("arst_busy", 16'(cmd_busy), 16'h0);
        chk("arst_resp", 16'(resp), 16'h0);
        chk("arst_ack", 16'(resp_ack), 16'h0);
        rst = 1'b0;
        tick();
        start(8'h05, 16'h0A0B);
        byte_step("hi7", 8'h0A);
        byte_step("lo7", 8'h0B);
        to_wait();
        respond(8'hA5, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
